// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM state codes and handshake levels.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic STALL_YES            = 1'b1;
    localparam logic STALL_NO             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) that stalls the pipeline
// while busy and returns {remainder, quotient} for the HI/LO write path.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2*DATA_W:0]     part_reg, part_next;
    logic [DATA_W-1:0]     divisor_reg, divisor_next;
    logic                  quo_neg_reg, quo_neg_next;
    logic                  rem_neg_reg, rem_neg_next;
    logic [2*DATA_W-1:0]   result_reg, result_next;

    logic                  trial_ge;
    logic [DATA_W-1:0]     trial_diff;
    logic [2*DATA_W:0]     part_step;
    logic [DATA_W-1:0]     quo_fix, rem_fix;
    logic                  abandon;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return '0 - v;
    endfunction

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? negate(v) : v;
    endfunction

    // part_reg holds {remainder, unconsumed dividend bits / quotient bits, spare}.
    // The trial window is the top DATA_W+1 bits: remainder shifted with the next dividend bit.
    assign trial_ge   = part_reg[2*DATA_W:DATA_W] >= {1'b0, divisor_reg};
    assign trial_diff = part_reg[2*DATA_W-1:DATA_W] - divisor_reg;
    assign part_step  = trial_ge ? {trial_diff, part_reg[DATA_W-1:0], 1'b1}
                                 : {part_reg[2*DATA_W-1:0], 1'b0};

    assign quo_fix = quo_neg_reg ? negate(part_step[DATA_W-1:0]) : part_step[DATA_W-1:0];
    assign rem_fix = rem_neg_reg ? negate(part_step[2*DATA_W:DATA_W+1])
                                 : part_step[2*DATA_W:DATA_W+1];

    // Dropping start_i before the result is seen is treated exactly like an annul.
    assign abandon = annul_i || (start_i == DIV_STOP);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        part_next    = part_reg;
        divisor_next = divisor_reg;
        quo_neg_next = quo_neg_reg;
        rem_neg_next = rem_neg_reg;
        result_next  = result_reg;
        ready_o      = DIV_RESULT_NOT_READY;
        stallreq_o   = STALL_NO;

        case (state_reg)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    stallreq_o   = STALL_YES;
                    cnt_next     = '0;
                    quo_neg_next = signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    rem_neg_next = signed_i && opdata1_i[DATA_W-1];
                    divisor_next = abs_val(opdata2_i, signed_i);
                    part_next    = {{DATA_W{1'b0}}, abs_val(opdata1_i, signed_i), 1'b0};
                    state_next   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                stallreq_o = STALL_YES;
                if (abandon) begin
                    state_next = DIV_FREE;
                end else begin
                    result_next = '0;
                    state_next  = DIV_END;
                end
            end
            DIV_ON: begin
                stallreq_o = STALL_YES;
                if (abandon) begin
                    state_next = DIV_FREE;
                end else begin
                    part_next = part_step;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        result_next = {rem_fix, quo_fix};
                        state_next  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                ready_o = DIV_RESULT_READY;
                if (abandon) begin
                    state_next = DIV_FREE;
                end
            end
            default: begin
                state_next = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= '0;
            part_reg    <= '0;
            divisor_reg <= '0;
            quo_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            part_reg    <= part_next;
            divisor_reg <= divisor_next;
            quo_neg_reg <= quo_neg_next;
            rem_neg_reg <= rem_neg_next;
            result_reg  <= result_next;
        end
    end

    assign result_o = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall window, sign handling,
// divide-by-zero, annul, mid-operation reset and result hold in END.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle. Raises start_i and waits (bounded) for ready_o.
    // lat = number of posedges from the raise until ready_o is seen (accept edge included).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output int stall);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        lat   = 0;
        stall = 0;
        #1;
        while (!ready_o && lat < 100) begin
            if (stallreq_o) stall++;
            @(negedge clk);
            lat++;
        end
        res = result_o;
    endtask

    task automatic finish_op();
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready_o); end
        checks++;
        if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h expected 0", result_o); end
        checks++;
        if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", stallreq_o); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat, stall;
        run_op(1'b0, 32'd100, 32'd7, res, lat, stall);
        checks++;
        if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_100_7 got %h expected %h", res, {32'd2, 32'd14}); end
        checks++;
        if (lat - 1 !== 32) begin errors++; $display("FAIL udiv_latency got %0d expected 32", lat - 1); end
        checks++;
        if (stall !== 33) begin errors++; $display("FAIL udiv_stall_cycles got %0d expected 33", stall); end
        finish_op();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL udiv_ready_drop got %b expected 0", ready_o); end
        $display("udiv 100/7 -> %h lat %0d stall %0d", res, lat - 1, stall);
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat, stall;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, stall);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2 got %h expected FFFFFFFFFFFFFFFD", res); end
        $display("sdiv -7/2 -> %h", res);
        finish_op();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, stall);
        checks++;
        if (res !== 64'h0000_0001_FFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2 got %h expected 00000001FFFFFFFD", res); end
        checks++;
        if (lat - 1 !== 32) begin errors++; $display("FAIL sdiv_latency got %0d expected 32", lat - 1); end
        $display("sdiv 7/-2 -> %h", res);
        finish_op();
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat, stall;
        run_op(1'b0, 32'd12345, 32'd0, res, lat, stall);
        checks++;
        if (res !== 64'h0) begin errors++; $display("FAIL divzero_result got %h expected 0", res); end
        checks++;
        if (lat - 1 !== 1) begin errors++; $display("FAIL divzero_latency got %0d expected 1", lat - 1); end
        checks++;
        if (stall !== 2) begin errors++; $display("FAIL divzero_stall got %0d expected 2", stall); end
        $display("divzero 12345/0 -> %h lat %0d stall %0d", res, lat - 1, stall);
        finish_op();
    endtask

    task automatic test_boundaries();
        logic [63:0] res;
        int lat, stall;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, stall);
        checks++;
        if (res !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL sdiv_overflow got %h expected 0000000080000000", res); end
        $display("sdiv 80000000/FFFFFFFF -> %h", res);
        finish_op();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat, stall);
        checks++;
        if (res !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL udiv_max_1 got %h expected 00000000FFFFFFFF", res); end
        $display("udiv FFFFFFFF/1 -> %h", res);
        finish_op();
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, res, lat, stall);
        checks++;
        if (res !== 64'h7FFF_FFFE_0000_0001) begin errors++; $display("FAIL udiv_big_divisor got %h expected 7FFFFFFE00000001", res); end
        $display("udiv FFFFFFFF/80000001 -> %h", res);
        finish_op();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat, stall;
        logic saw_ready;
        saw_ready = 1'b0;
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stallreq_o !== 1'b0) begin errors++; $display("FAIL annul_stall got %b expected 0", stallreq_o); end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        if (ready_o) saw_ready = 1'b1;
        checks++;
        if (saw_ready !== 1'b0) begin errors++; $display("FAIL annul_ready got %b expected 0", saw_ready); end
        run_op(1'b0, 32'd1000, 32'd3, res, lat, stall);
        checks++;
        if (res !== {32'd1, 32'd333}) begin errors++; $display("FAIL annul_restart got %h expected %h", res, {32'd1, 32'd333}); end
        $display("annul at iter 10, restart 1000/3 -> %h", res);
        finish_op();
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd500; opdata2_i = 32'd4;
        @(negedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (result_o !== 64'h0) begin errors++; $display("FAIL midrst_result got %h expected 0", result_o); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b expected 0", ready_o); end
        checks++;
        if (stallreq_o !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b expected 0", stallreq_o); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset at iter 20 -> result %h ready %b", result_o, ready_o);
    endtask

    task automatic test_hold_end();
        logic [63:0] res;
        int lat, stall;
        run_op(1'b1, 32'd91, 32'd10, res, lat, stall);
        checks++;
        if (res !== {32'd1, 32'd9}) begin errors++; $display("FAIL hold_result got %h expected %h", res, {32'd1, 32'd9}); end
        for (int i = 0; i < 5; i++) begin
            opdata1_i = 32'd7 + 32'(i);
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b1 || result_o !== {32'd1, 32'd9} || stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d got ready %b stall %b result %h expected ready 1 stall 0 result %h",
                         i, ready_o, stallreq_o, result_o, {32'd1, 32'd9});
            end
        end
        $display("hold in END 5 cycles -> %h", result_o);
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat, stall;
        finish_op();
        run_op(1'b0, 32'hDEAD_BEEF, 32'h10, res, lat, stall);
        checks++;
        if (res !== 64'h0000_000F_0DEA_DBEE || lat - 1 !== 32) begin
            errors++;
            $display("FAIL b2b_first got %h lat %0d expected 0000000F0DEADBEE lat 32", res, lat - 1);
        end
        $display("b2b DEADBEEF/10 -> %h", res);
        finish_op();
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, res, lat, stall);
        checks++;
        if (res !== 64'hFFFF_FFFE_FFFF_FFF2 || lat - 1 !== 32) begin
            errors++;
            $display("FAIL b2b_second got %h lat %0d expected FFFFFFFEFFFFFFF2 lat 32", res, lat - 1);
        end
        $display("b2b -100/7 -> %h", res);
        finish_op();
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundaries();
        test_annul();
        test_reset_mid();
        test_hold_end();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
